// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Arbitrates two word-wide requesters onto a byte-wide synchronous data
// memory. Each 32-bit access becomes four consecutive byte accesses,
// MSB byte first, at addresses base, base+1, base+2, base+3 (wrapping
// modulo the memory depth). Reads take one extra cycle (RTAIL) to collect
// the last byte returned by the memory.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   req0/req1            word access request (port 0 = CPU, port 1 = loader)
//   we0/we1              1 = write word, 0 = read word
//   addr0/addr1          byte address of the word's MSB byte
//   wdata0/wdata1        write word
//   ack0/ack1            one-cycle completion pulse
//   rdata0/rdata1        last word read on that port, valid from its ack
//   busy                 high whenever a transfer is in progress
//   mem_en/mem_we        byte strobe / byte write enable (registered)
//   mem_addr/mem_wdata   byte address / write byte (registered)
//   mem_rdata            read byte, valid the cycle after a mem_en read
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                   undefined -> fixed priority, port 0 wins ties
module dmem_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_RTAIL = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  // Remaining write bytes (next byte in [23:16]) and collected read bytes.
  logic [23:0]       wsh_q, wsh_d;
  logic [23:0]       sh_q, sh_d;

  logic              gnt_any;
  logic              gnt_sel;   // 1 = port 1 wins this IDLE cycle
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

`ifdef DMEM_ARB_RR_EN
  // Port granted most recently; resets to 1 so port 0 wins the first tie.
  logic              last_q, last_d;
`endif

  always_comb begin
    gnt_any = req0 | req1;
`ifdef DMEM_ARB_RR_EN
    gnt_sel = (req0 && req1) ? ~last_q : req1;
`else
    gnt_sel = ~req0;
`endif
    sel_we    = gnt_sel ? we1    : we0;
    sel_addr  = gnt_sel ? addr1  : addr0;
    sel_wdata = gnt_sel ? wdata1 : wdata0;
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    wsh_d       = wsh_q;
    sh_d        = sh_q;
`ifdef DMEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          state_d     = S_XFER;
          k_d         = 2'd0;
          gnt_d       = gnt_sel;
          we_d        = sel_we;
          // The first byte access is set up here so mem_* stay registered.
          mem_en_d    = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata[31:24];
          wsh_d       = sel_wdata[23:0];
`ifdef DMEM_ARB_RR_EN
          last_d      = gnt_sel;
`endif
        end
      end
      S_XFER: begin
        k_d = k_q + 2'd1;
        // The byte read at k-1 arrives now; nothing useful arrives at k = 0.
        if (k_q != 2'd0) sh_d = {sh_q[15:0], mem_rdata};
        if (k_q == 2'd3) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (we_q) begin
            state_d = S_ACK;
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
          end else begin
            state_d = S_RTAIL;
          end
        end else begin
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
          mem_wdata_d = wsh_q[23:16];
          wsh_d       = {wsh_q[15:0], 8'h00};
        end
      end
      S_RTAIL: begin
        // Last byte joins the word; rdata is loaded so it is valid with ack.
        state_d = S_ACK;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        if (gnt_q) rdata1_d = {sh_q, mem_rdata};
        else       rdata0_d = {sh_q, mem_rdata};
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      k_q         <= 2'd0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= 32'h0;
      rdata1_q    <= 32'h0;
`ifdef DMEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Byte shifters carry data only; their content is irrelevant after reset.
  always_ff @(posedge clk) begin
    wsh_q <= wsh_d;
    sh_q  <= sh_d;
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory, transaction-timeline model checked
// every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          ack0, ack1;
  logic [31:0]   rdata0, rdata1;
  logic          busy, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  bmem    [0:31];
  logic [7:0]  exp_mem [0:31];
  logic [31:0] exp_rd  [0:1];
  logic [4:0]  addr_log [$];
  bit          log_on = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Byte memory with one-cycle read latency.
  initial begin
    for (int i = 0; i < 32; i++) bmem[i] = 8'(128 + i);
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) bmem[mem_addr] = mem_wdata;
        else        mem_rdata <= bmem[mem_addr];
      end
    end
  end

  always @(negedge clk) if (log_on && mem_en) addr_log.push_back(mem_addr);

  // Reference model: a transaction granted in an idle cycle occupies phases
  // 1..4 for its bytes; a write acks in phase 5, a read idles in phase 5 and
  // acks in phase 6.
  initial begin
    bit          m_busy, m_we, e_en, e_ack;
    int          m_ph, m_port, m_base, m_last;
    logic [31:0] m_wdata, w;
    logic [4:0]  a;
    logic [7:0]  b;
    m_busy = 1'b0; m_we = 1'b0; m_ph = 0; m_port = 0; m_base = 0; m_last = 1;
    m_wdata = 32'h0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'(128 + i);
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        m_busy = 1'b0; m_ph = 0; m_last = 1;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      end else begin
        e_en  = m_busy && m_ph >= 1 && m_ph <= 4;
        e_ack = m_busy && ((m_we && m_ph == 5) || (!m_we && m_ph == 6));
        if (e_ack && !m_we) begin
          w = 32'h0;
          for (int i = 0; i < 4; i++) begin
            a = 5'(m_base + i);
            w = {w[23:0], exp_mem[a]};
          end
          exp_rd[m_port] = w;
        end
        a = 5'(m_base + m_ph - 1);
        b = 8'(m_wdata >> (8 * (4 - m_ph)));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        if (e_en) begin
          chk("mem_we", 32'(mem_we), 32'(m_we));
          chk("mem_addr", 32'(mem_addr), 32'(a));
          if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(b));
        end
        chk("ack0", 32'(ack0), 32'(e_ack && m_port == 0));
        chk("ack1", 32'(ack1), 32'(e_ack && m_port == 1));
        chk("rdata0", rdata0, exp_rd[0]);
        chk("rdata1", rdata1, exp_rd[1]);
        if (e_en && m_we) exp_mem[a] = b;
        if (m_busy) begin
          if (e_ack) m_busy = 1'b0;
          else       m_ph++;
        end else if (req0 || req1) begin
`ifdef DMEM_ARB_RR_EN
          if (req0 && req1) m_port = 1 - m_last;
          else              m_port = req1 ? 1 : 0;
`else
          m_port = req0 ? 0 : 1;
`endif
          m_last  = m_port;
          m_we    = (m_port == 0) ? we0 : we1;
          m_base  = (m_port == 0) ? int'(addr0) : int'(addr1);
          m_wdata = (m_port == 0) ? wdata0 : wdata1;
          m_busy  = 1'b1;
          m_ph    = 1;
        end
      end
    end
  end

  task automatic xfer(input int port, input bit we, input logic [4:0] addr,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd);
    @(posedge clk); #1;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else           begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    lat = -1;
    rd  = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        lat = i;
        rd  = (port == 0) ? rdata0 : rdata1;
        break;
      end
    end
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    chk("ack_seen", 32'(lat >= 0), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n;
    logic [31:0] rd;
    int          g [4];
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = 32'h0; wdata1 = 32'h0;
    @(posedge clk); #1;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_rdata0", rdata0, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Round trip: port 1 writes, port 0 reads back.
    xfer(1, 1'b1, 5'd8, 32'hDEADBEEF, lat, rd);
    chk("rt_wr_lat", 32'(lat), 32'd5);
    chk("rt_byte8", 32'(bmem[8]), 32'hDE);
    chk("rt_byte9", 32'(bmem[9]), 32'hAD);
    chk("rt_byte10", 32'(bmem[10]), 32'hBE);
    chk("rt_byte11", 32'(bmem[11]), 32'hEF);
    xfer(0, 1'b0, 5'd8, 32'h0, lat, rd);
    chk("rt_rd_lat", 32'(lat), 32'd6);
    chk("rt_rdata0", rd, 32'hDEADBEEF);

    // Wrap-around write at 30, then readback on port 1.
    log_on = 1'b1;
    xfer(0, 1'b1, 5'd30, 32'h11223344, lat, rd);
    log_on = 1'b0;
    chk("wrap_lat", 32'(lat), 32'd5);
    chk("wrap_nbytes", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      chk("wrap_a0", 32'(addr_log[0]), 32'd30);
      chk("wrap_a1", 32'(addr_log[1]), 32'd31);
      chk("wrap_a2", 32'(addr_log[2]), 32'd0);
      chk("wrap_a3", 32'(addr_log[3]), 32'd1);
    end
    xfer(1, 1'b0, 5'd30, 32'h0, lat, rd);
    chk("wrap_rd", rd, 32'h11223344);
    xfer(1, 1'b0, 5'd8, 32'h0, lat, rd);
    chk("p1_rd8", rd, 32'hDEADBEEF);

    // Withdraw req0 during a read; transfer still completes.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd30;
    repeat (2) @(posedge clk);
    #1 req0 = 1'b0;
    lat = -1;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack0) begin lat = i; break; end
    end
    chk("wd_lat", 32'(lat), 32'd6);
    chk("wd_rdata0", rdata0, 32'h11223344);
    chk("wd_rdata1", rdata1, 32'hDEADBEEF);
    xfer(0, 1'b1, 5'd12, 32'h55667788, lat, rd);
    chk("hold_rdata0", rdata0, 32'h11223344);

    // Simultaneous requests with both held high for four grants.
    do_reset();
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd0; wdata0 = 32'hC0C1C2C3;
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd4; wdata1 = 32'hD0D1D2D3;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(posedge clk); #1;
      if (ack0)      begin g[n] = 0; n++; end
      else if (ack1) begin g[n] = 1; n++; end
    end
    chk("sim_nacks", 32'(n), 32'd4);
    req0 = 1'b0;
`ifdef DMEM_ARB_RR_EN
    req1 = 1'b0;
    chk("sim_g0", 32'(g[0]), 32'd0);
    chk("sim_g1", 32'(g[1]), 32'd1);
    chk("sim_g2", 32'(g[2]), 32'd0);
    chk("sim_g3", 32'(g[3]), 32'd1);
`else
    chk("sim_g0", 32'(g[0]), 32'd0);
    chk("sim_g1", 32'(g[1]), 32'd0);
    chk("sim_g2", 32'(g[2]), 32'd0);
    chk("sim_g3", 32'(g[3]), 32'd0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack1) begin lat = i; break; end
    end
    req1 = 1'b0;
    chk("sim_p1_lat", 32'(lat), 32'd6);
`endif

    // Reset during byte k = 2 of a write.
    do_reset();
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd16; wdata0 = 32'hA1B2C3D4;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_addr", 32'(mem_addr), 32'd18);
    reset_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_mem_en", 32'(mem_en), 32'd0);
    chk("mid_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_ack0", 32'(ack0), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("mid_no_ack", 32'(ack0), 32'd0);
    end
    chk("mid_b16", 32'(bmem[16]), 32'hA1);
    chk("mid_b17", 32'(bmem[17]), 32'hB2);
    chk("mid_b18", 32'(bmem[18]), 32'h92);
    chk("mid_b19", 32'(bmem[19]), 32'h93);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
